// File: rtl/crc_bus_arbiter.sv
// Round-robin arbiter and burst sequencer for the shared CRC register bus.
// Each granted master gets one read or write burst; all outputs are registered.
module crc_bus_arbiter #(
  parameter int NREQ      = 2,
  parameter int MAX_BURST = 4,
  parameter int RD_LAT    = 1,
  localparam int LW       = $clog2(MAX_BURST)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ-1:0]               req_rw,
  input  logic [NREQ*32-1:0]            req_addr,
  input  logic [NREQ*LW-1:0]            req_len,
  input  logic [NREQ*32*MAX_BURST-1:0]  req_wdata,
  output logic [NREQ-1:0]               gnt,
  output logic [NREQ-1:0]               rvalid,
  output logic [31:0]                   rdata,
  output logic [NREQ-1:0]               done,
  output logic                          crc_sel,
  output logic                          crc_rw,
  output logic [31:0]                   crc_addr,
  output logic [31:0]                   crc_data_wr,
  input  logic [31:0]                   crc_data_rd
);

  localparam int PW = $clog2(NREQ);
  localparam int WW = $clog2(RD_LAT + 1);
  localparam int BW = 32 * MAX_BURST;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RWAIT, S_FIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_owner, w_owner_nxt;
  logic [PW-1:0]   r_rr_ptr, w_rr_nxt;
  logic [LW-1:0]   r_beat, w_beat_nxt;
  logic [WW-1:0]   r_wait, w_wait_nxt;
  logic [LW-1:0]   r_len;
  logic [BW-1:0]   r_wdata;
  logic [NREQ-1:0] r_gnt, r_rvalid, r_done;
  logic [NREQ-1:0] w_gnt_nxt, w_rvalid_nxt, w_done_nxt;
  logic [31:0]     r_rdata, w_rdata_nxt;
  logic            r_crc_sel, w_sel_nxt;
  logic            r_crc_rw, w_crc_rw_nxt;
  logic [31:0]     r_crc_addr, w_crc_addr_nxt;
  logic [31:0]     r_crc_wr, w_crc_wr_nxt;

  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [BW-1:0]   w_win_wdata;
  logic            w_load;
  logic            w_more;
  logic            w_step;
  logic [LW-1:0]   w_beat_inc;
  logic [31:0]     w_next_wr;

  // Search starts one past the last finisher, so it has lowest priority.
  always_comb begin : arb
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req[PW'(idx)]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
  end

  assign w_win_wdata = req_wdata[BW*int'(w_win) +: BW];
  assign w_load      = (r_state == S_IDLE) && w_found;
  assign w_more      = (r_beat < r_len);
  assign w_beat_inc  = r_beat + LW'(1);
  assign w_next_wr   = r_crc_rw ? r_wdata[32*int'(w_beat_inc) +: 32] : '0;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_rr_nxt       = r_rr_ptr;
    w_beat_nxt     = r_beat;
    w_wait_nxt     = r_wait;
    w_gnt_nxt      = '0;
    w_rvalid_nxt   = '0;
    w_done_nxt     = '0;
    w_sel_nxt      = 1'b0;
    w_rdata_nxt    = r_rdata;
    w_crc_rw_nxt   = r_crc_rw;
    w_crc_addr_nxt = r_crc_addr;
    w_crc_wr_nxt   = r_crc_wr;
    w_step         = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt      = S_ISSUE;
          w_owner_nxt      = w_win;
          w_gnt_nxt[w_win] = 1'b1;
          w_sel_nxt        = 1'b1;
          w_beat_nxt       = '0;
          w_crc_rw_nxt     = req_rw[w_win];
          w_crc_addr_nxt   = req_addr[32*int'(w_win) +: 32];
          w_crc_wr_nxt     = req_rw[w_win] ? w_win_wdata[31:0] : '0;
        end
      end
      S_ISSUE: begin
        if (!r_crc_rw) begin
          w_state_nxt = S_RWAIT;
          w_wait_nxt  = '0;
        end else if (w_more) begin
          w_step = 1'b1;
        end else begin
          w_state_nxt         = S_FIN;
          w_done_nxt[r_owner] = 1'b1;
        end
      end
      S_RWAIT: begin
        if (r_wait == WW'(RD_LAT - 1)) begin
          w_rvalid_nxt[r_owner] = 1'b1;
          w_rdata_nxt           = crc_data_rd;
          if (w_more) begin
            w_step = 1'b1;
          end else begin
            w_state_nxt         = S_FIN;
            w_done_nxt[r_owner] = 1'b1;
          end
        end else begin
          w_wait_nxt = r_wait + WW'(1);
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_rr_nxt    = r_owner;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Next beat of the current burst; address wraps naturally at 2^32.
    if (w_step) begin
      w_state_nxt    = S_ISSUE;
      w_sel_nxt      = 1'b1;
      w_beat_nxt     = w_beat_inc;
      w_crc_addr_nxt = r_crc_addr + 32'd4;
      w_crc_wr_nxt   = w_next_wr;
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= PW'(NREQ - 1);
      r_beat     <= '0;
      r_wait     <= '0;
      r_gnt      <= '0;
      r_rvalid   <= '0;
      r_done     <= '0;
      r_rdata    <= '0;
      r_crc_sel  <= 1'b0;
      r_crc_rw   <= 1'b0;
      r_crc_addr <= '0;
      r_crc_wr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_beat     <= w_beat_nxt;
      r_wait     <= w_wait_nxt;
      r_gnt      <= w_gnt_nxt;
      r_rvalid   <= w_rvalid_nxt;
      r_done     <= w_done_nxt;
      r_rdata    <= w_rdata_nxt;
      r_crc_sel  <= w_sel_nxt;
      r_crc_rw   <= w_crc_rw_nxt;
      r_crc_addr <= w_crc_addr_nxt;
      r_crc_wr   <= w_crc_wr_nxt;
    end
  end

  // NOTE: the burst data store is not reset; it is always reloaded at grant before any beat reads it.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_len   <= req_len[LW*int'(w_win) +: LW];
      r_wdata <= w_win_wdata;
    end
  end

  assign gnt         = r_gnt;
  assign rvalid      = r_rvalid;
  assign rdata       = r_rdata;
  assign done        = r_done;
  assign crc_sel     = r_crc_sel;
  assign crc_rw      = r_crc_rw;
  assign crc_addr    = r_crc_addr;
  assign crc_data_wr = r_crc_wr;

endmodule

// File: tb/tb_crc_bus_arbiter.sv
// Bench for crc_bus_arbiter: a burst-schedule model predicts every output per cycle,
// directed scenarios pin the model with literal values, then random traffic runs.
module tb_crc_bus_arbiter;

  localparam int NREQ      = 2;
  localparam int MAX_BURST = 4;
  localparam int RD_LAT    = 1;
  localparam int LW        = $clog2(MAX_BURST);
  localparam int BW        = 32 * MAX_BURST;
  localparam int P         = RD_LAT + 1;
  localparam int MAXC      = 20000;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req, req_rw;
  logic [NREQ*32-1:0]    req_addr;
  logic [NREQ*LW-1:0]    req_len;
  logic [NREQ*BW-1:0]    req_wdata;
  logic [NREQ-1:0]       gnt, rvalid, done;
  logic [31:0]           rdata;
  logic                  crc_sel, crc_rw;
  logic [31:0]           crc_addr, crc_data_wr, crc_data_rd;

  crc_bus_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .done(done), .crc_sel(crc_sel), .crc_rw(crc_rw),
    .crc_addr(crc_addr), .crc_data_wr(crc_data_wr), .crc_data_rd(crc_data_rd)
  );

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  // ---------------- expected-output schedule ----------------
  typedef struct packed {
    logic            clr;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rvalid;
    logic [NREQ-1:0] done;
    logic            sel;
    logic            rw;
    logic [31:0]     addr;
    logic [31:0]     wr;
    logic [31:0]     rd;
  } slot_t;

  slot_t exp_a [MAXC];
  int    m_free = 0;
  int    m_rr   = NREQ - 1;

  // At each edge: reset wipes pending work; otherwise an arbitration edge lays
  // the whole burst out on the timeline using its latency formulas.
  task automatic model_step();
    int n, w, nb, t, idx;
    logic [31:0] base;
    logic [BW-1:0] wd;
    logic rw;
    n = cyc;
    if (!rst) begin
      for (int i = 0; i < 128; i++) exp_a[n+i] = '0;
      exp_a[n].clr = 1'b1;
      m_rr   = NREQ - 1;
      m_free = n + 1;
    end else if (n >= m_free && req != '0) begin
      w = -1;
      for (int i = 1; i <= NREQ; i++) begin
        idx = (m_rr + i) % NREQ;
        if (w < 0 && req[idx]) w = idx;
      end
      rw   = req_rw[w];
      base = req_addr[32*w +: 32];
      nb   = int'(req_len[LW*w +: LW]) + 1;
      wd   = req_wdata[BW*w +: BW];
      exp_a[n].gnt[w] = 1'b1;
      for (int b = 0; b < nb; b++) begin
        t = rw ? n + b : n + b * P;
        exp_a[t].sel  = 1'b1;
        exp_a[t].rw   = rw;
        exp_a[t].addr = base + 32'(4 * b);
        exp_a[t].wr   = rw ? wd[32*b +: 32] : 32'd0;
        if (!rw) begin
          exp_a[n+(b+1)*P].rvalid[w] = 1'b1;
          exp_a[n+(b+1)*P].rd        = mem_f(base + 32'(4 * b));
        end
      end
      t = rw ? n + nb : n + nb * P;
      exp_a[t].done[w] = 1'b1;
      m_free = t + 2;
      m_rr   = w;
    end
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) exp_a[i] = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (cyc < MAXC - 200) model_step();
    end
  end

  // ---------------- CRC bus read responder ----------------
  logic [31:0] rd_pipe [RD_LAT];
  initial begin
    crc_data_rd = 32'h0;
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 32'h0;
    forever begin
      @(negedge clk);
      crc_data_rd = rd_pipe[RD_LAT-1];
      for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
      rd_pipe[0] = (crc_sel && !crc_rw) ? mem_f(crc_addr) : $urandom;
    end
  end

  // ---------------- event logs for directed checks ----------------
  typedef struct {
    int          cyc;
    int          m;
    logic [31:0] a;
    logic [31:0] d;
    logic        rw;
  } ev_t;

  ev_t sel_q[$], gnt_q[$], rv_q[$], done_q[$];

  function automatic ev_t at_q(input ev_t q[$], input int i);
    ev_t e;
    e.cyc = -1; e.m = -1; e.a = '0; e.d = '0; e.rw = 1'b0;
    if (i < q.size()) e = q[i];
    return e;
  endfunction

  task automatic clear_logs();
    sel_q.delete(); gnt_q.delete(); rv_q.delete(); done_q.delete();
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    slot_t       s;
    ev_t         e;
    logic        h_rw;
    logic [31:0] h_addr, h_wr, h_rd;
    h_rw = 1'b0; h_addr = '0; h_wr = '0; h_rd = '0;
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < MAXC - 200) begin
        s = exp_a[cyc];
        if (s.clr) begin
          h_rw = 1'b0; h_addr = '0; h_wr = '0; h_rd = '0;
        end
        if (s.sel) begin
          h_rw = s.rw; h_addr = s.addr; h_wr = s.wr;
        end
        if (s.rvalid != '0) h_rd = s.rd;
        check("gnt",         32'(gnt),    32'(s.gnt));
        check("rvalid",      32'(rvalid), 32'(s.rvalid));
        check("done",        32'(done),   32'(s.done));
        check("crc_sel",     32'(crc_sel), 32'(s.sel));
        check("crc_rw",      32'(crc_rw), 32'(h_rw));
        check("crc_addr",    crc_addr,    h_addr);
        check("crc_data_wr", crc_data_wr, h_wr);
        check("rdata",       rdata,       h_rd);
      end
      e.cyc = cyc; e.a = crc_addr; e.d = crc_data_wr; e.rw = crc_rw; e.m = 0;
      if (crc_sel) sel_q.push_back(e);
      for (int m = 0; m < NREQ; m++) begin
        e.m = m; e.d = rdata;
        if (gnt[m])    gnt_q.push_back(e);
        if (rvalid[m]) rv_q.push_back(e);
        if (done[m])   done_q.push_back(e);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int m, input logic rw, input logic [31:0] a,
                         input int len, input logic [BW-1:0] wd);
    req_rw[m]              = rw;
    req_addr[32*m +: 32]   = a;
    req_len[LW*m +: LW]    = LW'(len);
    req_wdata[BW*m +: BW]  = wd;
    req[m]                 = 1'b1;
  endtask

  function automatic logic [BW-1:0] rand_wd();
    logic [BW-1:0] wd;
    for (int b = 0; b < MAX_BURST; b++) wd[32*b +: 32] = $urandom;
    return wd;
  endfunction

  task automatic wait_done(input int m, input int budget, input bit drop_at_gnt);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (drop_at_gnt && gnt[m]) req[m] = 1'b0;
      if (done[m]) begin
        req[m] = 1'b0;
        seen   = 1'b1;
      end
    end
    check($sformatf("done%0d_within_budget", m), 32'(seen), 32'd1);
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    clear_logs();
  endtask

  // ---------------- main sequence ----------------
  bit pend [NREQ];
  bit busy [NREQ];

  initial begin
    logic [31:0] exp4 [4];
    int          k;
    rst = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_len = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    clear_logs();

    // 1: single-word write from master 0
    set_req(0, 1'b1, 32'h10, 0, {{(BW-32){1'b0}}, 32'hDEAD_BEEF});
    wait_done(0, 20, 1'b0);
    check("t1_sel_count", 32'(sel_q.size()), 32'd1);
    check("t1_addr",      at_q(sel_q, 0).a, 32'h10);
    check("t1_wdata",     at_q(sel_q, 0).d, 32'hDEAD_BEEF);
    check("t1_gnt_m",     32'(at_q(gnt_q, 0).m), 32'd0);
    check("t1_done_gap",  32'(at_q(done_q, 0).cyc - at_q(gnt_q, 0).cyc), 32'd1);
    clear_logs();

    // 2: four-word read from master 1
    set_req(1, 1'b0, 32'h20, 3, rand_wd());
    wait_done(1, 40, 1'b0);
    exp4[0] = 32'hA5A5_A585; exp4[1] = 32'hA5A5_A581;
    exp4[2] = 32'hA5A5_A58D; exp4[3] = 32'hA5A5_A589;
    check("t2_rvalid_count", 32'(rv_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_addr%0d", i),  at_q(sel_q, i).a, 32'h20 + 32'(4 * i));
      check($sformatf("t2_rdata%0d", i), at_q(rv_q, i).d, exp4[i]);
      check($sformatf("t2_rv_m%0d", i),  32'(at_q(rv_q, i).m), 32'd1);
    end
    check("t2_sel_gap",   32'(at_q(sel_q, 1).cyc - at_q(sel_q, 0).cyc), 32'd2);
    check("t2_done_cyc",  32'(at_q(done_q, 0).cyc), 32'(at_q(rv_q, 3).cyc));

    // 3: contention from reset, both masters hold req
    reset_pulse();
    set_req(0, 1'b1, 32'h100, 0, rand_wd());
    set_req(1, 1'b1, 32'h200, 0, rand_wd());
    k = 0;
    while (done_q.size() < 4 && k < 80) begin
      @(negedge clk);
      #1;
      k++;
    end
    req = '0;
    check("t3_four_done", 32'(done_q.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_order%0d", i), 32'(at_q(gnt_q, i).m), 32'(i % 2));
    repeat (3) @(negedge clk);
    #1;
    clear_logs();

    // 4: address wrap on a write burst
    set_req(0, 1'b1, 32'hFFFF_FFF8, 3, rand_wd());
    wait_done(0, 20, 1'b0);
    exp4[0] = 32'hFFFF_FFF8; exp4[1] = 32'hFFFF_FFFC;
    exp4[2] = 32'h0000_0000; exp4[3] = 32'h0000_0004;
    for (int i = 0; i < 4; i++)
      check($sformatf("t4_addr%0d", i), at_q(sel_q, i).a, exp4[i]);
    clear_logs();

    // 5: reset during the second beat of a read burst
    set_req(1, 1'b0, 32'h300, 3, rand_wd());
    k = 0;
    while (sel_q.size() < 2 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("t5_rst_gnt",    32'(gnt),    32'd0);
    check("t5_rst_rvalid", 32'(rvalid), 32'd0);
    check("t5_rst_done",   32'(done),   32'd0);
    check("t5_rst_sel",    32'(crc_sel), 32'd0);
    check("t5_rst_addr",   crc_addr,    32'd0);
    check("t5_rst_rdata",  rdata,       32'd0);
    rst = 1'b1;
    clear_logs();
    set_req(0, 1'b0, 32'h400, 0, rand_wd());
    wait_done(0, 20, 1'b0);
    wait_done(1, 40, 1'b0);
    check("t5_first_gnt",  32'(at_q(gnt_q, 0).m), 32'd0);
    check("t5_second_gnt", 32'(at_q(gnt_q, 1).m), 32'd1);
    check("t5_restart",    at_q(sel_q, 1).a, 32'h300);
    check("t5_sel_count",  32'(sel_q.size()), 32'd5);
    check("t5_done_count", 32'(done_q.size()), 32'd2);
    repeat (2) @(negedge clk);
    #1;
    clear_logs();

    // 6: master drops req in its grant cycle
    set_req(0, 1'b0, 32'h40, 1, rand_wd());
    wait_done(0, 20, 1'b1);
    repeat (8) @(negedge clk);
    #1;
    check("t6_gnt_count",  32'(gnt_q.size()), 32'd1);
    check("t6_sel_count",  32'(sel_q.size()), 32'd2);
    check("t6_done_count", 32'(done_q.size()), 32'd1);

    // random traffic with occasional resets
    for (int m = 0; m < NREQ; m++) begin
      pend[m] = 1'b0;
      busy[m] = 1'b0;
    end
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!rst) begin
        rst = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0;
        req = '0;
        for (int m = 0; m < NREQ; m++) begin
          pend[m] = 1'b0;
          busy[m] = 1'b0;
        end
      end else begin
        for (int m = 0; m < NREQ; m++) begin
          if (gnt[m]) begin
            pend[m] = 1'b0;
            busy[m] = 1'b1;
            if ($urandom_range(0, 1) == 1) req[m] = 1'b0;
          end else if (done[m]) begin
            busy[m] = 1'b0;
            req[m]  = 1'b0;
          end else if (!pend[m] && !busy[m] && $urandom_range(0, 3) == 0) begin
            set_req(m, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom,
                    $urandom_range(0, MAX_BURST - 1), rand_wd());
            pend[m] = 1'b1;
          end
          if (busy[m]) begin
            req_addr[32*m +: 32] = $urandom;
            req_rw[m]            = 1'($urandom_range(0, 1));
          end
        end
      end
    end
    req = '0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
